// File: rtl/pulse_meas_pkg.sv
// Shared types and default sizing for the pulse measurement controller.
package pulse_meas_pkg;

    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned WIN_W_DEF      = 16;
    localparam int unsigned RST_CYC_DEF    = 8;
    localparam int unsigned SETTLE_CYC_DEF = 4;

    typedef enum logic [2:0] {
        StIdle,
        StRst,
        StSettle,
        StCount,
        StDone
    } state_e;

endpackage

// File: rtl/pulse_sync.sv
// Two-flop synchronizer followed by a rising-edge detector on the synchronized signal.
module pulse_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic rise
);

    // [0],[1] form the synchronizer, [2] holds the previous synchronized value
    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], d_async};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pulse_meas_ctrl.sv
// Gated pulse counter: resets the analog block, lets it settle, counts PULSE_1V8 edges
// over a programmable window and hands the result over with a valid/ready handshake.
module pulse_meas_ctrl
    import pulse_meas_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned WIN_W      = WIN_W_DEF,
    parameter int unsigned RST_CYC    = RST_CYC_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIN_W-1:0] cfg_window,
    input  logic             PULSE_1V8,
    output logic             RESET_1V8,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_ovf
);

    localparam int unsigned PH_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned TMR_W  = (WIN_W > PH_W) ? WIN_W : PH_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               rst_1v8_q, rst_1v8_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic               rise;
    logic               tmr_zero;

    pulse_sync u_pulse_sync (
        .clk     (clk),
        .reset   (reset),
        .d_async (PULSE_1V8),
        .rise    (rise)
    );

    assign tmr_zero = (tmr_q == '0);

    // One down-counter times RST, SETTLE and COUNT; each phase loads its length minus one.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRst;
                    win_d   = cfg_window;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    tmr_d   = TMR_W'(RST_CYC - 1);
                end
            end
            StRst: begin
                if (tmr_zero) begin
                    state_d = StSettle;
                    tmr_d   = TMR_W'(SETTLE_CYC - 1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            StSettle: begin
                if (!tmr_zero) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (win_q == '0) begin
                    state_d = StDone;
                end else begin
                    state_d = StCount;
                    tmr_d   = TMR_W'(win_q) - TMR_W'(1);
                end
            end
            StCount: begin
                if (rise) begin
                    if (cnt_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (tmr_zero) begin
                    state_d = StDone;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so the registers line up with the state.
        rst_1v8_d = (state_d == StIdle) || (state_d == StRst) || (state_d == StDone);
        busy_d    = (state_d != StIdle);
        valid_d   = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            tmr_q     <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            rst_1v8_q <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            rst_1v8_q <= rst_1v8_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign RESET_1V8 = rst_1v8_q;
    assign busy      = busy_q;
    assign res_valid = valid_q;
    assign res_count = cnt_q;
    assign res_ovf   = ovf_q;

endmodule
